// File: rtl/fir_pkg.sv
// Shared constants and frame-sequencing state encoding for the FIR output path.
package fir_pkg;

   localparam int DATA_WIDTH = 18;
   localparam int ACC_WIDTH  = 3 * DATA_WIDTH;

   localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } fsm_state_t;

endpackage

// File: rtl/fir_sample_fifo.sv
// First-word fall-through sample FIFO. head_data reads zero while empty so the
// consumer side never sees stale contents after reset or drain.
module fir_sample_fifo #(
   parameter  int WIDTH = 18,
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [PW:0]      count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW:0]      wr_ptr;
   logic [PW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra wrap bit so full and empty stay distinguishable.
   assign count   = wr_ptr - rd_ptr;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign head_data = empty ? '0 : mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr[PW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + (PW+1)'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + (PW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/fir_output_quantizer.sv
// Rounds and saturates fir_convolution accumulator samples back to DATA_WIDTH and
// queues them behind a valid/ready handshake, one frame of SAMPLE_COUNT at a time.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_RUN   | accepting accumulator samples until the frame count expires
// ST_DRAIN | input closed, waiting for pipeline and FIFO to empty
// ST_DONE  | one-cycle frame_done pulse
module fir_output_quantizer #(
   parameter int DATA_WIDTH   = fir_pkg::DATA_WIDTH,
   parameter int ACC_WIDTH    = DATA_WIDTH * 3,
   parameter int SHIFT        = 17,
   parameter int SAMPLE_COUNT = 60,
   parameter int FIFO_DEPTH   = 4,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ACC_WIDTH-1:0]  acc_in,
   input  logic                  acc_valid,
   output logic                  acc_ready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   input  logic                  data_ready,
   output logic [CNT_WIDTH-1:0]  sat_count,
   output logic                  busy,
   output logic                  frame_done
);

   import fir_pkg::fsm_state_t;
   import fir_pkg::ST_IDLE;
   import fir_pkg::ST_RUN;
   import fir_pkg::ST_DRAIN;
   import fir_pkg::ST_DONE;

   localparam int FPW = $clog2(FIFO_DEPTH);
   localparam int OCW = FPW + 2;
   localparam int SCW = $clog2(SAMPLE_COUNT + 1);
   localparam int RW  = ACC_WIDTH + 1;

   localparam logic [SCW-1:0]       SAMPLES   = SCW'(SAMPLE_COUNT);
   localparam logic [OCW-1:0]       OCC_LIMIT = OCW'(FIFO_DEPTH);
   localparam logic signed [RW-1:0] RND_HALF  = RW'(1) << (SHIFT - 1);
   localparam logic signed [RW-1:0] HI_LIM    = {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [RW-1:0] LO_LIM    = {{(RW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   fsm_state_t            state;
   logic [SCW-1:0]        samp_left;
   logic                  xfer;

   logic signed [RW-1:0]  acc_ext;
   logic signed [RW-1:0]  acc_sum;
   logic signed [RW-1:0]  acc_rnd;

   logic                  s1_valid;
   logic signed [RW-1:0]  s1_val;
   logic                  s2_valid;
   logic                  s2_sat;
   logic [DATA_WIDTH-1:0] s2_data;

   logic                  clamp_sat;
   logic [DATA_WIDTH-1:0] clamp_data;

   logic [FPW:0]          fifo_count;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [OCW-1:0]        occupancy;
   logic                  path_empty;

   // One guard bit above the accumulator keeps the rounding add from wrapping.
   assign acc_ext = {acc_in[ACC_WIDTH-1], acc_in};
   assign acc_sum = acc_ext + RND_HALF;
   assign acc_rnd = acc_sum >>> SHIFT;

   always_comb begin
      clamp_data = s1_val[DATA_WIDTH-1:0];
      clamp_sat  = 1'b0;
      if (s1_val > HI_LIM) begin
         clamp_data = HI_LIM[DATA_WIDTH-1:0];
         clamp_sat  = 1'b1;
      end else if (s1_val < LO_LIM) begin
         clamp_data = LO_LIM[DATA_WIDTH-1:0];
         clamp_sat  = 1'b1;
      end
   end

   // Samples in flight reserve FIFO slots up front, so the pipeline never stalls.
   assign occupancy  = {1'b0, fifo_count} + OCW'(s1_valid) + OCW'(s2_valid);
   assign acc_ready  = (state == ST_RUN) && !fifo_full && (occupancy < OCC_LIMIT);
   assign xfer       = acc_valid && acc_ready;
   assign data_valid = !fifo_empty;
   assign path_empty = !s1_valid && !s2_valid && fifo_empty;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_val   <= '0;
         s2_valid <= 1'b0;
         s2_sat   <= 1'b0;
         s2_data  <= '0;
      end else begin
         s1_valid <= xfer;
         s1_val   <= acc_rnd;
         s2_valid <= s1_valid;
         s2_sat   <= clamp_sat;
         s2_data  <= clamp_data;
      end
   end

   fir_sample_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (s2_valid),
      .push_data (s2_data),
      .pop       (data_ready),
      .head_data (data_out),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         samp_left  <= '0;
         sat_count  <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (s2_valid && s2_sat && (sat_count != '1)) begin
            sat_count <= sat_count + CNT_WIDTH'(1);
         end
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_RUN;
                  samp_left <= SAMPLES;
                  sat_count <= '0;
                  busy      <= 1'b1;
               end
            end
            ST_RUN: begin
               if (xfer) begin
                  samp_left <= samp_left - SCW'(1);
                  if (samp_left == SCW'(1)) begin
                     state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (path_empty) begin
                  state      <= ST_DONE;
                  frame_done <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_output_quantizer.sv
// Bench for fir_output_quantizer: a frame-level reference model compared every
// cycle, plus directed vectors with hand-derived results.
module tb_fir_output_quantizer;

   localparam int     DW   = 18;
   localparam int     AW   = 54;
   localparam int     SH   = 17;
   localparam int     NS   = 60;
   localparam int     FD   = 4;
   localparam longint HALF = longint'(1) << (SH - 1);
   localparam longint OMAX = (longint'(1) << (DW - 1)) - 1;
   localparam longint OMIN = -(longint'(1) << (DW - 1));
   localparam longint BIG  = longint'(1) << 40;

   localparam int P_IDLE  = 0;
   localparam int P_RUN   = 1;
   localparam int P_DRAIN = 2;
   localparam int P_DONE  = 3;

   logic          clock      = 1'b0;
   logic          reset_n    = 1'b0;
   logic          start      = 1'b0;
   logic [AW-1:0] acc_in     = '0;
   logic          acc_valid  = 1'b0;
   logic          data_ready = 1'b1;

   logic          acc_ready, data_valid, busy, frame_done;
   logic [DW-1:0] data_out;
   logic [15:0]   sat_count;
   logic          acc_ready2, data_valid2, busy2, frame_done2;
   logic [DW-1:0] data_out2;
   logic [1:0]    sat_count2;

   int total = 0;
   int bad   = 0;

   typedef struct {
      longint val;
      bit     sat;
      int     rdy;
   } ent_t;

   ent_t   mq[$];
   int     m_phase = P_IDLE;
   int     m_left  = 0;
   int     m_sat_popped = 0;
   int     cyc = 0;
   int     fd_cnt = 0;
   longint got[$];

   always #5 clock = ~clock;

   fir_output_quantizer dut (
      .clock(clock), .reset_n(reset_n), .start(start), .acc_in(acc_in),
      .acc_valid(acc_valid), .acc_ready(acc_ready), .data_out(data_out),
      .data_valid(data_valid), .data_ready(data_ready), .sat_count(sat_count),
      .busy(busy), .frame_done(frame_done)
   );

   fir_output_quantizer #(.CNT_WIDTH(2)) dut_c2 (
      .clock(clock), .reset_n(reset_n), .start(start), .acc_in(acc_in),
      .acc_valid(acc_valid), .acc_ready(acc_ready2), .data_out(data_out2),
      .data_valid(data_valid2), .data_ready(data_ready), .sat_count(sat_count2),
      .busy(busy2), .frame_done(frame_done2)
   );

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Round half up toward +inf at the binary point, then clamp to DW bits.
   function automatic longint rounded(input longint a);
      return (a + HALF) >>> SH;
   endfunction

   function automatic longint quant(input longint a);
      longint r;
      r = rounded(a);
      if (r > OMAX) r = OMAX;
      if (r < OMIN) r = OMIN;
      return r;
   endfunction

   function automatic longint ramp(input int i);
      return (longint'(i * 3 - 90) <<< SH) + 12345;
   endfunction

   always @(negedge clock) begin
      bit     e_valid, e_ready;
      longint e_data;
      int     e_sat, pre_size;
      ent_t   e;
      if (!reset_n) begin
         mq.delete();
         m_phase = P_IDLE;
         m_left = 0;
         m_sat_popped = 0;
         check("rst_acc_ready", acc_ready, 0);
         check("rst_data_valid", data_valid, 0);
         check("rst_data_out", data_out, 0);
         check("rst_sat_count", sat_count, 0);
         check("rst_busy", busy, 0);
         check("rst_frame_done", frame_done, 0);
      end else begin
         e_valid = (mq.size() > 0) && (mq[0].rdy <= cyc);
         e_data  = e_valid ? mq[0].val : 0;
         e_ready = (m_phase == P_RUN) && (mq.size() < FD);
         e_sat   = m_sat_popped;
         foreach (mq[i]) if (mq[i].sat && mq[i].rdy <= cyc) e_sat++;
         check("acc_ready", acc_ready, e_ready);
         check("data_valid", data_valid, e_valid);
         check("data_out", longint'($signed(data_out)), e_data);
         check("busy", busy, m_phase != P_IDLE);
         check("frame_done", frame_done, m_phase == P_DONE);
         check("sat_count", sat_count, (e_sat > 65535) ? 65535 : e_sat);
         check("acc_ready_c2", acc_ready2, e_ready);
         check("data_valid_c2", data_valid2, e_valid);
         check("data_out_c2", longint'($signed(data_out2)), e_data);
         check("busy_c2", busy2, m_phase != P_IDLE);
         check("frame_done_c2", frame_done2, m_phase == P_DONE);
         check("sat_count_c2", sat_count2, (e_sat > 3) ? 3 : e_sat);

         pre_size = mq.size();
         if (e_valid && data_ready) begin
            if (mq[0].sat) m_sat_popped++;
            void'(mq.pop_front());
         end
         if (acc_valid && e_ready) begin
            e.val = quant($signed(acc_in));
            e.sat = (rounded($signed(acc_in)) != e.val);
            e.rdy = cyc + 3;
            mq.push_back(e);
            m_left--;
         end
         case (m_phase)
            P_IDLE:  if (start) begin m_phase = P_RUN; m_left = NS; m_sat_popped = 0; end
            P_RUN:   if (acc_valid && e_ready && m_left == 0) m_phase = P_DRAIN;
            P_DRAIN: if (pre_size == 0) m_phase = P_DONE;
            default: m_phase = P_IDLE;
         endcase
      end
      cyc++;
   end

   always @(negedge clock) begin
      if (reset_n && frame_done) fd_cnt++;
      if (reset_n && data_valid && data_ready) got.push_back(longint'($signed(data_out)));
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input longint v);
      int n;
      n = 0;
      acc_valid = 1'b1;
      acc_in = AW'(v);
      while (!acc_ready && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) check("send_timeout", n, 0);
      tick();
      acc_valid = 1'b0;
   endtask

   // Streams NS ramp samples with acc_valid held high; optional extra start pulse at sample 30.
   task automatic stream(input bit bp_probe, input bit start_probe);
      int  k;
      bit  took;
      bit  pulsed;
      k = 0;
      pulsed = 1'b0;
      acc_valid = 1'b1;
      acc_in = AW'(ramp(0));
      for (int c = 0; c < 600 && k < NS; c++) begin
         if (bp_probe && c == 20) begin
            check("bp_xfers", k, 4);
            check("bp_ready_low", acc_ready, 0);
            data_ready = 1'b1;
         end
         start = start_probe && (k == 30) && !pulsed;
         if (start) pulsed = 1'b1;
         took = acc_ready;
         tick();
         if (took) begin
            k++;
            acc_in = AW'(ramp(k));
         end
      end
      start = 1'b0;
      check("stream_count", k, NS);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 400) begin
         tick();
         n++;
      end
      if (n >= 400) check("idle_timeout", n, 0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      check("q_3p0", quant(393216), 3);
      check("q_p0p5", quant(65536), 1);
      check("q_m0p5", quant(-65536), 0);
      check("q_m1p5", quant(-196608), -1);
      check("q_big", quant(BIG), 131071);
      check("q_mbig", quant(-BIG), -131072);
      reset_n = 1'b1;
      repeat (2) tick();

      // Rounding and 3-cycle latency
      fd_cnt = 0;
      pulse_start();
      send(393216);
      check("lat_n1", data_valid, 0);
      tick();
      check("lat_n2", data_valid, 0);
      tick();
      check("lat_n3", data_valid, 1);
      check("lat_data", longint'($signed(data_out)), 3);
      send(65536);
      send(-65536);
      send(-196608);
      repeat (NS - 4) send(0);
      wait_idle();
      check("a_sat", sat_count, 0);
      check("a_done", fd_cnt, 1);

      // Saturation, including the 2-bit counter holding at all-ones
      fd_cnt = 0;
      pulse_start();
      send(BIG);
      send(-BIG);
      repeat (4) tick();
      check("b_sat2", sat_count, 2);
      repeat (3) send(BIG);
      repeat (NS - 5) send(0);
      wait_idle();
      check("b_sat5", sat_count, 5);
      check("b_sat_c2", sat_count2, 3);
      check("b_done", fd_cnt, 1);

      // Backpressure, then in-order ramp
      fd_cnt = 0;
      got.delete();
      data_ready = 1'b0;
      pulse_start();
      stream(1'b1, 1'b0);
      acc_valid = 1'b0;
      wait_idle();
      check("c_len", got.size(), NS);
      foreach (got[i]) check("c_ramp", got[i], i * 3 - 90);
      check("c_done", fd_cnt, 1);

      // Frame end, 61st valid ignored, start in RUN and DRAIN ignored
      fd_cnt = 0;
      pulse_start();
      stream(1'b0, 1'b1);
      check("d_ready_after", acc_ready, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("d_ready_drain", acc_ready, 0);
      acc_valid = 1'b0;
      wait_idle();
      check("d_done", fd_cnt, 1);
      check("d_sat", sat_count, 0);

      // Asynchronous reset mid-frame
      pulse_start();
      send(BIG);
      send(BIG);
      repeat (18) send(0);
      check("e_sat_pre", sat_count, 2);
      #2;
      reset_n = 1'b0;
      #1;
      check("e_acc_ready", acc_ready, 0);
      check("e_data_valid", data_valid, 0);
      check("e_data_out", data_out, 0);
      check("e_sat", sat_count, 0);
      check("e_busy", busy, 0);
      check("e_frame_done", frame_done, 0);
      repeat (2) tick();
      reset_n = 1'b1;
      tick();

      // Clean frame after reset
      fd_cnt = 0;
      pulse_start();
      check("f_sat_clear", sat_count, 0);
      check("f_busy", busy, 1);
      for (int i = 0; i < NS; i++) send(ramp(i));
      wait_idle();
      check("f_done", fd_cnt, 1);
      check("f_sat", sat_count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
